// File: rtl/latch_bank_sync_if.sv
// Capture read-back port of latch_bank_sync.
// The debug consumer pops and flushes the close-event FIFO through this port.
interface latch_bank_sync_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW = $clog2(DEPTH);

   logic          cap_rd;
   logic          cap_clear;
   logic          cap_valid;
   logic [CW-1:0] cap_chan;
   logic [WIDTH-1:0] cap_data;
   logic [AW:0]   cap_count;
   logic [7:0]    cap_drops;

   modport master (
      output cap_rd, cap_clear,
      input  cap_valid, cap_chan, cap_data, cap_count, cap_drops
   );

   modport slave (
      input  cap_rd, cap_clear,
      output cap_valid, cap_chan, cap_data, cap_count, cap_drops
   );
endinterface

// File: rtl/latch_bank_sync.sv
// Clocked bank of transparent-latch emulators (74S373 successor) with a
// FIFO recording the value each channel froze on when its hold_n closed.
module latch_bank_sync #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   parameter int MODE     = 0,
   parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       hold_n,
   input  logic [CHANNELS-1:0]       oenb_n,
   input  logic [CHANNELS*WIDTH-1:0] i,
   output wire  [CHANNELS*WIDTH-1:0] o,
   output logic [CHANNELS*WIDTH-1:0] q,
   latch_bank_sync_if.slave          cap
);
   localparam int AW = $clog2(DEPTH);

   logic [CHANNELS*WIDTH-1:0] q_r;
   logic [CHANNELS-1:0]       hold_d;
   logic [CHANNELS-1:0]       pend_v;
   logic [WIDTH-1:0]          pend_d [CHANNELS];
   logic [CW-1:0]             mem_chan [DEPTH];
   logic [WIDTH-1:0]          mem_data [DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [AW:0]               count;
   logic [7:0]                drops, drops_next;

   logic [CHANNELS-1:0]       close_ev, push_sel, pushed, drop_ev;
   logic [CW-1:0]             push_chan;
   logic                      full, push, pop;
   int                        drop_total;

   assign close_ev = hold_d & ~hold_n;
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop      = cap.cap_rd && (count != '0);

   // Lowest-index pending channel wins the single FIFO write slot.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      push_sel  = '0;
      push_chan = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (pend_v[c]) begin
            push_sel    = '0;
            push_sel[c] = 1'b1;
            push_chan   = CW'(c);
         end
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign push    = (|push_sel) && (!full || pop);
   assign pushed  = push ? push_sel : '0;
   assign drop_ev = close_ev & pend_v & ~pushed;

   always_comb begin
      drop_total = int'(drops);
      for (int c = 0; c < CHANNELS; c++) drop_total += int'(drop_ev[c]);
      drops_next = (drop_total > 255) ? 8'd255 : 8'(drop_total);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_r    <= '0;
         hold_d <= '0;
         pend_v <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drops  <= '0;
      end else begin
         hold_d <= hold_n;
         for (int c = 0; c < CHANNELS; c++)
            if (hold_n[c]) q_r[c*WIDTH +: WIDTH] <= i[c*WIDTH +: WIDTH];

         if (cap.cap_clear) begin
            pend_v <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
         end else begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (close_ev[c])    pend_v[c] <= 1'b1;
               else if (pushed[c]) pend_v[c] <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
            drops <= drops_next;
         end
      end
   end

   // NOTE: storage arrays carry no reset; pend_v and the FIFO pointers qualify them.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++)
         if (close_ev[c]) pend_d[c] <= q_r[c*WIDTH +: WIDTH];
      if (push) begin
         mem_chan[wr_ptr] <= push_chan;
         mem_data[wr_ptr] <= pend_d[push_chan];
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_out
      logic [WIDTH-1:0] mux;
      assign mux = (MODE == 0 && hold_n[c]) ? i[c*WIDTH +: WIDTH] : q_r[c*WIDTH +: WIDTH];
      assign o[c*WIDTH +: WIDTH] = oenb_n[c] ? {WIDTH{1'bz}} : mux;
   end

   assign q             = q_r;
   assign cap.cap_valid = (count != '0);
   assign cap.cap_chan  = mem_chan[rd_ptr];
   assign cap.cap_data  = mem_data[rd_ptr];
   assign cap.cap_count = count;
   assign cap.cap_drops = drops;
endmodule

// File: doc/latch_bank_sync.md
Name: latch_bank_sync

Overview:
- Parametrised, clock-synchronous successor to the part_74S373 octal transparent latch model.
- Provides CHANNELS independent WIDTH-bit latches, each with its own hold_n and oenb_n. MODE selects transparent emulation or registered operation.
- Adds a latch-close capture FIFO so debug logic can read back the value each latch froze on.
- Sits between board-level bus sources (e.g. CADR busses) and consumers in place of discrete 74S373 parts.

Parameters:
WIDTH, 8, bits per latch channel
CHANNELS, 2, number of independent latch channels
DEPTH, 4, capture FIFO entries (power of two, >=2)
MODE, 0, 0 = transparent emulation, 1 = registered (one-clock latency)
CW, max(1,clog2(CHANNELS)), channel index width (derived, do not override)

Ports:
clk  in  1  sole clock, all state updates on rising edge
reset_n  in  1  reset, synchronous, active-low
hold_n  in  CHANNELS  per-channel latch enable (1 = open/transparent, 0 = hold)
oenb_n  in  CHANNELS  per-channel output enable, active-low
i  in  CHANNELS*WIDTH  data in; channel c at [c*WIDTH +: WIDTH]
o  out  CHANNELS*WIDTH  tristate data out, same packing
q  out  CHANNELS*WIDTH  latched state, always driven (debug)
cap_rd  in  1  pop capture FIFO head
cap_clear  in  1  flush FIFO, pending flags, drop counter
cap_valid  out  1  FIFO non-empty
cap_chan  out  CW  channel of head entry
cap_data  out  WIDTH  latched value of head entry
cap_count  out  clog2(DEPTH)+1  entries held
cap_drops  out  8  dropped close events, saturates at 255

Behaviour:
- Reset: one clock, synchronous, active-low. On the reset_n=0 edge: q=0; hold_n_d (previous-sample register)=0, so hold_n=0 out of reset generates no close event; pending=0; FIFO empty; cap_drops=0. Reset mid-operation discards everything on that edge.
- Latch state: on each clk with hold_n[c]=1, q[c] <= i[c]. With hold_n[c]=0, q[c] holds.
- Output mux, MODE=0: the o value is i[c] when hold_n[c]=1 (combinational, zero latency), else q[c].
- Output mux, MODE=1: the o value is q[c] always (one-clock latency from i).
- Output enable: o[c] = 'z' when oenb_n[c]=1, else the mux value. oenb_n never affects q.
- Close event: hold_n_d[c]=1 and hold_n[c]=0 at a clk edge. The captured value is q[c] after that edge, i.e. i sampled at the last edge with hold_n=1.
- Each close loads the per-channel pending register: pend_v[c]=1, pend_d[c]=value. If pend_v[c] is already 1, the old value is overwritten and cap_drops increments.
- Arbiter: each cycle, push the lowest-index pending channel into the FIFO as {chan, data} and clear its pend_v. A close event in the same cycle as that channel's push re-sets pend_v with the new value.
- FIFO full: the push is refused, pending stays set, no drop is counted. A later re-close overwrites and counts as a drop.
- Read: cap_rd with cap_valid pops the head. cap_rd when empty is ignored.
- Push and pop in the same cycle are allowed, including when full; cap_count is unchanged.
- Head outputs (cap_chan, cap_data) are valid whenever cap_valid=1; their values when empty are don't-care. Pointers wrap modulo DEPTH.
- cap_clear: priority over push, pop and close bookkeeping that cycle. Empties the FIFO, clears pend_v and cap_drops. Leaves q untouched.
- cap_drops saturates at 255 and never wraps.

Test Plan:
1. CHANNELS=2, WIDTH=8, MODE=0, reset with hold_n=00.
   - oenb_n=11 -> o=zz.
   - oenb_n=00 -> o=0x00,0x00; cap_valid=0.
2. Transparency, ch0: hold_n[0]=1, i0=0x5A -> o0=0x5A same cycle. Then i0=0x3C -> o0=0x3C.
   - Drop hold_n[0] coincident with i0=0xFF -> o0=0x3C.
   - Next cycle cap_valid=1, cap_chan=0, cap_data=0x3C.
3. MODE=1: hold_n[0]=1, i0 steps 0x01,0x02 on successive clocks -> o0 lags one clock.
   - Close -> capture holds the last value sampled with hold_n=1.
4. Simultaneous close of ch0 (0x11) and ch1 (0x22) -> FIFO holds {0,0x11} then {1,0x22} on consecutive cycles; cap_count=2.
5. DEPTH=4 overflow:
   - Six ch0/ch1 closes with no reads -> cap_count=4.
   - Re-closes while pending -> cap_drops=2; pop order is oldest first.
   - cap_rd while full with pending -> count stays 4.
6. Mid-run with 3 entries:
   - cap_clear=1 -> next cycle cap_count=0, cap_drops=0, q unchanged.
   - reset_n=0 -> q=0, no close event on release.
